// File: rtl/md_if.sv
// Handshake and result bundle between the EX-stage control/hazard logic and the
// multiply/divide unit.
interface md_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        cancel;
    logic        busy;
    logic        stall_req;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (
        output start, op, A, B, cancel,
        input  busy, stall_req, HI, LO
    );

    modport slave (
        input  start, op, A, B, cancel,
        output busy, stall_req, HI, LO
    );
endinterface

// File: rtl/md_unit.sv
// EX-stage multiply/divide unit. It holds HI/LO, runs mult/div as fixed-latency
// multi-cycle operations and performs single-cycle mthi/mtlo writes.
module md_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic CLK,
    input  logic reset,
    md_if.slave  md
);
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state_reg, state_next;
    logic [3:0]  cnt_reg, cnt_next;
    logic [31:0] hi_reg, hi_next;
    logic [31:0] lo_reg, lo_next;
    logic [31:0] pend_hi_reg, pend_hi_next;
    logic [31:0] pend_lo_reg, pend_lo_next;
    logic        pend_wr_reg, pend_wr_next;

    logic        accept;
    logic        is_md_op;
    logic [63:0] prod_s, prod_u;
    logic        div_signed;
    logic [31:0] divisor_safe;
    logic [31:0] dvd_mag, dvs_mag;
    logic [31:0] uq, ur;
    logic [31:0] quot, rem;

    assign is_md_op = (md.op == OP_MULT) || (md.op == OP_MULTU) ||
                      (md.op == OP_DIV)  || (md.op == OP_DIVU);
    assign accept   = md.start & ~md.cancel & (state_reg == IDLE);

    // Sign-extended 64-bit operands give the signed product modulo 2^64.
    assign prod_s = {{32{md.A[31]}}, md.A} * {{32{md.B[31]}}, md.B};
    assign prod_u = {32'd0, md.A} * {32'd0, md.B};

    // Signed divide runs on magnitudes so 0x80000000 / -1 needs no special case;
    // a zero divisor is replaced to keep the divider defined (result is discarded).
    assign div_signed   = (md.op == OP_DIV);
    assign divisor_safe = (md.B == 32'd0) ? 32'd1 : md.B;
    assign dvd_mag      = (div_signed && md.A[31]) ? (32'd0 - md.A) : md.A;
    assign dvs_mag      = (div_signed && divisor_safe[31]) ? (32'd0 - divisor_safe) : divisor_safe;
    assign uq           = dvd_mag / dvs_mag;
    assign ur           = dvd_mag % dvs_mag;
    assign quot         = (div_signed && (md.A[31] ^ md.B[31])) ? (32'd0 - uq) : uq;
    assign rem          = (div_signed && md.A[31]) ? (32'd0 - ur) : ur;

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            cnt_reg     <= 4'd0;
            hi_reg      <= 32'd0;
            lo_reg      <= 32'd0;
            pend_hi_reg <= 32'd0;
            pend_lo_reg <= 32'd0;
            pend_wr_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            hi_reg      <= hi_next;
            lo_reg      <= lo_next;
            pend_hi_reg <= pend_hi_next;
            pend_lo_reg <= pend_lo_next;
            pend_wr_reg <= pend_wr_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        hi_next      = hi_reg;
        lo_next      = lo_reg;
        pend_hi_next = pend_hi_reg;
        pend_lo_next = pend_lo_reg;
        pend_wr_next = pend_wr_reg;

        case (state_reg)
            IDLE: begin
                if (accept) begin
                    case (md.op)
                        OP_MULT, OP_MULTU: begin
                            {pend_hi_next, pend_lo_next} = (md.op == OP_MULT) ? prod_s : prod_u;
                            pend_wr_next = 1'b1;
                            cnt_next     = 4'(MULT_CYCLES);
                            state_next   = RUN;
                        end
                        OP_DIV, OP_DIVU: begin
                            pend_hi_next = rem;
                            pend_lo_next = quot;
                            pend_wr_next = (md.B != 32'd0);
                            cnt_next     = 4'(DIV_CYCLES);
                            state_next   = RUN;
                        end
                        OP_MTHI: hi_next = md.A;
                        OP_MTLO: lo_next = md.A;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                if (cnt_reg <= 4'd1) begin
                    cnt_next   = 4'd0;
                    state_next = IDLE;
                    if (pend_wr_reg) begin
                        hi_next = pend_hi_reg;
                        lo_next = pend_lo_reg;
                    end
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign md.busy      = (state_reg == RUN);
    assign md.stall_req = md.busy | (md.start & ~md.cancel & is_md_op);
    assign md.HI        = hi_reg;
    assign md.LO        = lo_reg;
endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multiply/divide unit in the EX stage, directly upstream of the EX/MEM pipeline register.
- Executes mult/multu/div/divu as multi-cycle operations and holds the HI/LO architectural registers. Also performs the single-cycle mthi/mtlo writes.
- Exports `busy` and `stall_req` so the hazard unit can hold mfhi/mflo/md instructions in EX.
- The EX-stage mux forwards HI/LO into the AO field that the EX/MEM register captures.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (legal range 1..15).
- DIV_CYCLES, 10, busy cycles for div/divu (legal range 1..15).

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  EX-stage instruction is an MD op this cycle.
- op  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none).
- A  input  32  rs operand (forwarded value).
- B  input  32  rt operand (forwarded value).
- cancel  input  1  exception/interrupt flush of the EX instruction this cycle; suppresses start.
- busy  output  1  operation in flight.
- stall_req  output  1  combinational: busy | (start & ~cancel & op in {1..4}).
- HI  output  32  HI register.
- LO  output  32  LO register.

Behaviour:
- Reset (asynchronous, any time including mid-operation):
  - HI=0, LO=0, busy=0, internal counter=0, pending result=0.
  - An in-flight operation is discarded.
  - stall_req then follows its combinational equation.
- States: IDLE (busy=0) and RUN (busy=1).
- Accept condition at an edge: start=1 & cancel=0 & busy=0.
  - An accepted start is always sampled by the edge that ends the cycle in which it is presented.
  - Any start while busy=1 is ignored; the hazard unit guarantees it is held.
- mult/multu accepted at edge T:
  - Full 64-bit product of A and B is computed and latched into pending {hi,lo]. Signed for mult, unsigned for multu.
  - Counter loads MULT_CYCLES; busy=1 after T.
- div/divu accepted at edge T:
  - pending lo = quotient, hi = remainder. Counter loads DIV_CYCLES; busy=1 after T.
  - Signed div truncates toward zero; the remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF (signed): LO=0x80000000, HI=0.
  - Divide by zero: still busy for DIV_CYCLES, but HI/LO stay unchanged at completion.
- In RUN, the counter decrements at each edge.
  - At the edge where counter==1: HI/LO take the pending values, counter becomes 0, busy becomes 0.
  - Net effect: busy is high for exactly N cycles, and new HI/LO are visible after edge T+N.
- A new op can be accepted at the edge after busy falls (edge T+N+1 at the earliest). There is no back-to-back overlap.
- mthi/mtlo accepted at edge T: HI (resp. LO) = A after T. busy stays 0 and stall_req is 0 for these ops.
- cancel=1: the op is not accepted, no state changes, and stall_req from start is masked.
  - cancel has no effect on an operation already in RUN.
- op 0/7 with start=1: no effect.
- HI/LO change only at operation completion, on mthi/mtlo, or on reset.

Test Plan:
- Reset=1 asynchronously, no clock edge -> HI=0, LO=0, busy=0 immediately.
- multu with A=B=0xFFFFFFFF at edge T -> busy=1 for 5 cycles; at T+5, HI=0xFFFFFFFE, LO=0x00000001, busy=0; stall_req=1 in the start cycle.
- mult with A=0xFFFFFFFD (-3), B=5 -> after 5 cycles HI=0xFFFFFFFF, LO=0xFFFFFFF1. Then div with A=0xFFFFFFF9 (-7), B=2 -> busy 10 cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- Preload mthi 0x12345678 and mtlo 0x9ABCDEF0 (each single cycle, busy stays 0). Then divu with B=0 -> busy 10 cycles, HI/LO unchanged. Then div 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- start=1 with op=mult and cancel=1 -> busy stays 0, HI/LO unchanged, stall_req=0. Separately, mthi presented while busy=1 -> ignored, HI unchanged after completion except by the MD result.
- Assert reset 3 cycles into a div -> busy=0, HI=LO=0 immediately. After release, a new multu 2*3 completes normally with LO=6, HI=0.
